seg_scan_decoder: RTL and testbench

Receive-side counterpart of the hex-to-seven-segment encoder. This block monitors a multiplexed 4-digit seven-segment bus, consisting of an active-low segment pattern plus an active-low digit anode select. It recovers the 16-bit hex value being displayed and publishes it once per complete scan frame. It serves as an on-chip readback and self-check of the score/status display path and as a scoreboard tap for display-driver verification.

---
 rtl/seg_scan_decoder.sv | 177 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers the 16-bit hex value shown on a
// multiplexed active-low 4-digit seven-segment bus, one publish per frame.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic        valid,
    output logic [3:0]  digit_err,
    output logic        stale
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        PUBLISH
    } state_t;

    state_t state_q, state_d;

    logic [6:0]    s_seg, p_seg;
    logic [3:0]    s_an, p_an;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    seen_q, seen_d, seen_eff;
    logic [15:0]   shd_nib_q, shd_nib_d;
    logic [3:0]    shd_err_q, shd_err_d;
    logic [15:0]   value_d;
    logic [3:0]    err_d;
    logic          valid_d, stale_d;

    logic          onehot, same, capture, done;
    logic [1:0]    idx;
    logic [4:0]    dec_r;

    // glyph -> {error, nibble}; anything unlisted is flagged
    function automatic logic [4:0] dec(input logic [6:0] p);
        case (p)
            7'b0000001: dec = 5'h00;
            7'b1001111: dec = 5'h01;
            7'b0010010: dec = 5'h02;
            7'b0000110: dec = 5'h03;
            7'b1001100: dec = 5'h04;
            7'b0100100: dec = 5'h05;
            7'b0100000: dec = 5'h06;
            7'b0001111: dec = 5'h07;
            7'b0000000: dec = 5'h08;
            7'b0000100: dec = 5'h09;
            7'b0001000: dec = 5'h0A;
            7'b1100000: dec = 5'h0B;
            7'b0110001: dec = 5'h0C;
            7'b1000010: dec = 5'h0D;
            7'b0110000: dec = 5'h0E;
            7'b0111000: dec = 5'h0F;
            default:    dec = 5'h10;
        endcase
    endfunction

    // register the pins, and keep the previous sample for stability compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_seg <= 7'h7F;
            s_an  <= 4'hF;
            p_seg <= 7'h7F;
            p_an  <= 4'hF;
        end else begin
            s_seg <= seg;
            s_an  <= an;
            p_seg <= s_seg;
            p_an  <= s_an;
        end
    end

    // anode decode: only a single low anode selects a digit
    always_comb begin
        onehot = $onehot(~s_an);
        idx    = 2'd0;
        unique case (1'b1)
            onehot && !s_an[0]: idx = 2'd0;
            onehot && !s_an[1]: idx = 2'd1;
            onehot && !s_an[2]: idx = 2'd2;
            onehot && !s_an[3]: idx = 2'd3;
            default:            idx = 2'd0;
        endcase
    end

    // next-state: stability, capture, publish and timeout
    always_comb begin
        same      = (s_seg == p_seg) && (s_an == p_an);
        dec_r     = dec(s_seg);
        seen_eff  = (state_q == PUBLISH) ? 4'h0 : seen_q;
        seen_d    = seen_eff;
        shd_nib_d = shd_nib_q;
        shd_err_d = shd_err_q;
        value_d   = value;
        err_d     = digit_err;
        valid_d   = 1'b0;
        stale_d   = stale;
        tmo_d     = tmo_q + TW'(1);
        state_d   = state_q;
        cnt_d     = cnt_q;

        if (!onehot)
            cnt_d = '0;
        else if (!same)
            cnt_d = CW'(1);
        else if (cnt_q != CW'(STABLE_CYCLES))
            cnt_d = cnt_q + CW'(1);

        capture = onehot && same &&
                  (cnt_q == CW'(STABLE_CYCLES - 1)) &&
                  !seen_eff[idx];

        if (capture) begin
            seen_d[idx]               = 1'b1;
            shd_nib_d[{idx, 2'b00} +: 4] = dec_r[3:0];
            shd_err_d[idx]            = dec_r[4];
        end

        done = capture && (seen_d == 4'hF);

        if (done) begin
            value_d = shd_nib_d;
            err_d   = shd_err_d;
            valid_d = 1'b1;
            stale_d = 1'b0;
            tmo_d   = '0;
            state_d = PUBLISH;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            stale_d = 1'b1;
            tmo_d   = '0;
            seen_d  = 4'h0;
            state_d = IDLE;
        end else begin
            state_d = (seen_d == 4'h0) ? IDLE : COLLECT;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            tmo_q     <= '0;
            seen_q    <= 4'h0;
            shd_nib_q <= 16'h0;
            shd_err_q <= 4'h0;
            value     <= 16'h0;
            digit_err <= 4'h0;
            valid     <= 1'b0;
            stale     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            seen_q    <= seen_d;
            shd_nib_q <= shd_nib_d;
            shd_err_q <= shd_err_d;
            value     <= value_d;
            digit_err <= err_d;
            valid     <= valid_d;
            stale     <= stale_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scans of the display bus with a
// scoreboard of expected published frames.
module tb_seg_scan_decoder;

    logic        clk;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic        valid;
    logic [3:0]  digit_err;
    logic        stale;

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] sb[$];
    logic        prev_valid = 1'b0;

    seg_scan_decoder #(
        .STABLE_CYCLES (4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .seg      (seg),
        .an       (an),
        .value    (value),
        .valid    (valid),
        .digit_err(digit_err),
        .stale    (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // hex digit -> active-low glyph (A is bit 6, G is bit 0)
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b0000001;
            4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;
            4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;
            4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;
            4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0000100;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b1100000;
            4'hC: glyph = 7'b0110001;
            4'hD: glyph = 7'b1000010;
            4'hE: glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every valid pulse pops one expected frame
    always @(negedge clk) begin
        logic [19:0] e;
        if (!rst && valid) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got value=%h err=%b expected none",
                         value, digit_err);
            end else begin
                e = sb.pop_front();
                if ({value, digit_err} !== e) begin
                    n_fail++;
                    $display("FAIL frame: got value=%h err=%b expected value=%h err=%b",
                             value, digit_err, e[19:4], e[3:0]);
                end
            end
            n_checks++;
            if (prev_valid) begin
                n_fail++;
                $display("FAIL valid_width: got 2+ cycle pulse expected 1");
            end
        end
        prev_valid = valid;
    end

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] v, input int cyc);
        logic [3:0] a;
        for (int d = 0; d < 4; d++) begin
            a = 4'b0001 << d;
            hold(~a, glyph(v[4*d +: 4]), cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        an  = 4'hF;
        seg = 7'h7F;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // wait (bounded) for the scoreboard to empty
    task automatic drain(input string name);
        int k;
        an  = 4'hF;
        seg = 7'h7F;
        k   = 0;
        while (sb.size() != 0 && k < 12) begin
            @(negedge clk);
            k++;
        end
        chk(name, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        an  = 4'hF;
        seg = 7'h7F;
        @(negedge clk);

        // reset with garbage on the pins
        rst = 1'b1;
        an  = 4'b0110;
        seg = 7'b1010101;
        repeat (3) @(negedge clk);
        an  = 4'hF;
        seg = 7'h7F;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_value", value, 16'h0);
        chk("rst_err", digit_err, 4'h0);
        chk("rst_stale", stale, 0);
        chk("rst_valid", valid, 0);

        // nominal scan twice, then frames exercising every glyph
        do_reset();
        sb.push_back({16'h1A3F, 4'h0});
        sb.push_back({16'h1A3F, 4'h0});
        send_frame(16'h1A3F, 8);
        send_frame(16'h1A3F, 8);
        drain("drain_nominal");
        sb.push_back({16'h3210, 4'h0});
        sb.push_back({16'h7654, 4'h0});
        sb.push_back({16'hBA98, 4'h0});
        sb.push_back({16'hFEDC, 4'h0});
        send_frame(16'h3210, 6);
        send_frame(16'h7654, 6);
        send_frame(16'hBA98, 6);
        send_frame(16'hFEDC, 6);
        drain("drain_glyphs");
        chk("nominal_stale", stale, 0);

        // glitch: 7 for 3 cycles, then 2 for 8 on the same anode
        do_reset();
        sb.push_back({16'h9C62, 4'h0});
        hold(4'b1110, glyph(4'h7), 3);
        hold(4'b1110, glyph(4'h2), 8);
        hold(4'b1101, glyph(4'h6), 8);
        hold(4'b1011, glyph(4'hC), 8);
        hold(4'b0111, glyph(4'h9), 8);
        drain("drain_glitch");

        // illegal glyph: blank on digit 2
        do_reset();
        sb.push_back({16'h1034, 4'b0100});
        hold(4'b1110, glyph(4'h4), 8);
        hold(4'b1101, glyph(4'h3), 8);
        hold(4'b1011, 7'b1111111, 8);
        hold(4'b0111, glyph(4'h1), 8);
        drain("drain_illegal");

        // invalid anode until timeout, then a good frame
        do_reset();
        an  = 4'b0011;
        seg = glyph(4'h8);
        repeat (60) @(negedge clk);
        chk("stale_before", stale, 0);
        repeat (8) @(negedge clk);
        chk("stale_after", stale, 1);
        chk("stale_value_held", value, 16'h0);
        sb.push_back({16'h5A5A, 4'h0});
        send_frame(16'h5A5A, 8);
        drain("drain_timeout");
        chk("stale_cleared", stale, 0);

        // reset mid-frame after two captured digits
        do_reset();
        hold(4'b1110, glyph(4'h5), 8);
        hold(4'b1101, glyph(4'h5), 8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_value", value, 16'h0);
        sb.push_back({16'hBEEF, 4'h0});
        send_frame(16'hBEEF, 8);
        drain("drain_midrst");

        repeat (5) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
